// File: rtl/fp_div_unit.sv
// Single-precision floating-point divider.
// Special operands resolve in one cycle. Everything else runs a 26-step
// restoring division, then normalises and rounds to nearest-even.
// Denormal inputs are flushed to signed zero.
// One operation is in flight at a time. The result is held until the
// writeback bus accepts it.
module fp_div_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero_division,
    output logic             out_invalid,
    output logic             out_overflow,
    output logic             out_underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [4:0]  LAST_ITER = 5'd25;

    state_t state;
    state_t state_next;

    // Operation accepted only from IDLE; a flush kills the handshake.
    logic accept;

    // Operand decode on the issue-side inputs.
    logic        a_sign;
    logic        b_sign;
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;
    logic        a_nan;
    logic        b_nan;
    logic        res_sign;
    logic        is_special;
    logic [31:0] spec_result;
    logic        spec_zd;
    logic        spec_inv;
    logic signed [9:0] exp_calc;

    // Division state.
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [24:0]       rem_q;
    logic [23:0]       div_q;
    logic [25:0]       quot_q;
    logic [4:0]        iter_cnt;

    // One restoring-division step.
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    // Normalise and round.
    logic [23:0]       norm_mant;
    logic              norm_guard;
    logic              norm_sticky;
    logic signed [9:0] norm_exp;
    logic              round_up;
    logic [24:0]       mant_rounded;
    logic [22:0]       final_frac;
    logic signed [9:0] final_exp;
    logic [31:0]       norm_result;
    logic              norm_of;
    logic              norm_uf;

    assign accept    = in_valid && (state == IDLE) && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign a_sign = in_a[31];
    assign b_sign = in_b[31];
    assign a_exp  = in_a[30:23];
    assign b_exp  = in_b[30:23];
    assign a_frac = in_a[22:0];
    assign b_frac = in_b[22:0];

    // A zero exponent covers true zeros and the flushed denormals.
    assign a_zero   = (a_exp == 8'd0);
    assign b_zero   = (b_exp == 8'd0);
    assign a_inf    = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf    = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign a_nan    = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan    = (b_exp == 8'hFF) && (b_frac != 23'd0);
    assign res_sign = a_sign ^ b_sign;

    assign exp_calc = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;

    // Resolve special operands. Priority: invalid, infinite dividend,
    // divide by zero, then the cases that give a signed-zero result.
    always_comb begin
        is_special  = 1'b1;
        spec_result = 32'd0;
        spec_zd     = 1'b0;
        spec_inv    = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result = QNAN;
            spec_inv    = 1'b1;
        end else if (a_inf) begin
            spec_result = {res_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_result = {res_sign, 8'hFF, 23'd0};
            spec_zd     = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_result = {res_sign, 31'd0};
        end else begin
            is_special  = 1'b0;
        end
    end

    // One quotient bit per cycle: subtract the divisor if it fits, then shift.
    always_comb begin
        rem_ge   = (rem_q >= {1'b0, div_q});
        rem_sub  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_next = rem_sub << 1;
    end

    // Normalise the 26-bit quotient, round to nearest even and check range.
    always_comb begin
        if (quot_q[25]) begin
            norm_mant   = quot_q[25:2];
            norm_guard  = quot_q[1];
            norm_sticky = quot_q[0] | (rem_q != 25'd0);
            norm_exp    = exp_q;
        end else begin
            norm_mant   = quot_q[24:1];
            norm_guard  = quot_q[0];
            norm_sticky = (rem_q != 25'd0);
            norm_exp    = exp_q - 10'sd1;
        end
        round_up     = norm_guard & (norm_sticky | norm_mant[0]);
        mant_rounded = {1'b0, norm_mant} + {24'd0, round_up};
        if (mant_rounded[24]) begin
            final_frac = mant_rounded[23:1];
            final_exp  = norm_exp + 10'sd1;
        end else begin
            final_frac = mant_rounded[22:0];
            final_exp  = norm_exp;
        end
        norm_of     = 1'b0;
        norm_uf     = 1'b0;
        if (final_exp >= 10'sd255) begin
            norm_result = {sign_q, 8'hFF, 23'd0};
            norm_of     = 1'b1;
        end else if (final_exp <= 10'sd0) begin
            norm_result = {sign_q, 31'd0};
            norm_uf     = 1'b1;
        end else begin
            norm_result = {sign_q, final_exp[7:0], final_frac};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_special ? DONE : DIV;
                end
            end
            DIV: begin
                if (iter_cnt == LAST_ITER) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Datapath and result registers. Outputs change only on accept of a
    // special case or when leaving NORM, so they stay stable in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q            <= 1'b0;
            exp_q             <= 10'sd0;
            rem_q             <= 25'd0;
            div_q             <= 24'd0;
            quot_q            <= 26'd0;
            iter_cnt          <= 5'd0;
            out_result        <= '0;
            out_tag           <= '0;
            out_zero_division <= 1'b0;
            out_invalid       <= 1'b0;
            out_overflow      <= 1'b0;
            out_underflow     <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        if (is_special) begin
                            out_result        <= spec_result;
                            out_zero_division <= spec_zd;
                            out_invalid       <= spec_inv;
                            out_overflow      <= 1'b0;
                            out_underflow     <= 1'b0;
                        end else begin
                            sign_q   <= res_sign;
                            exp_q    <= exp_calc;
                            rem_q    <= {2'b01, a_frac};
                            div_q    <= {1'b1, b_frac};
                            quot_q   <= 26'd0;
                            iter_cnt <= 5'd0;
                        end
                    end
                end
                DIV: begin
                    rem_q    <= rem_next;
                    quot_q   <= {quot_q[24:0], rem_ge};
                    iter_cnt <= iter_cnt + 5'd1;
                end
                NORM: begin
                    out_result        <= norm_result;
                    out_zero_division <= 1'b0;
                    out_invalid       <= 1'b0;
                    out_overflow      <= norm_of;
                    out_underflow     <= norm_uf;
                    iter_cnt          <= 5'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
